fp32_to_int: RTL
================

FP32_TO_INT -- requirements
Module: fp32_to_int

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: in_fp32 carries a request.
REQ-004 SHALL have port in_ready, output, 1 bit: high only in IDLE.
REQ-005 SHALL have port in_fp32, input, 32 bits: IEEE-754 single operand {sign, exp[7:0], man[22:0]}.
REQ-006 SHALL have port out_valid, output, 1 bit: out_int and out_invalid are valid; high only in DONE.
REQ-007 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-008 SHALL have port out_int, output, 32 bits: converted integer, truncated toward zero.
REQ-009 SHALL have port out_invalid, output, 1 bit: NaN, Inf, out-of-range or illegal-sign input.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-011 SHALL accept an operand on a clk edge with in_valid=1 in IDLE, capture it and classify with e = exp - 127.
REQ-012 SHALL apply these classes, default build, unsigned result:
- exp=0 (zero or denormal), or e<0 (either sign): result 0, invalid 0.
- exp=255 with man!=0 (NaN): result 0xFFFFFFFF, invalid 1.
- +Inf: result 0xFFFFFFFF, invalid 1.
- -Inf: result 0, invalid 1.
- sign=1 with e>=0: result 0, invalid 1.
- e>=32: result 0xFFFFFFFF, invalid 1.
REQ-013 SHALL treat the remaining case, 0<=e<=31, as in-range: significand S={1,man} (24 bits) in a 32-bit work register, shift count N=|23-e|, right shift if e<23, left shift if e>23.
REQ-014 SHALL go IDLE->DONE on the accept edge when the class is special or N=0, with out_int/out_invalid loaded on that edge.
REQ-015 SHALL go IDLE->SHIFT when N>0.
REQ-016 SHALL, in SHIFT, shift the work register by one bit per cycle and decrement the counter; the final shift loads out_int and goes to DONE.
REQ-017 SHALL assert out_valid exactly N+1 cycles after the accept edge (N=0 for special classes).
REQ-018 SHALL hold out_valid, out_int and out_invalid stable in DONE until a clk edge with out_ready=1, then go to IDLE.
REQ-019 SHALL hold in_ready=0 in SHIFT and DONE and ignore in_valid there; the earliest next accept is the cycle after the handshake.
REQ-020 SHALL discard right-shifted bits (truncation) and never set invalid for precision loss.

Reset
REQ-021 SHALL, on a clk edge with rst_n=0 (including mid-SHIFT or in DONE), go to IDLE and clear out_valid=0, out_int=0, out_invalid=0 and the work register and counter.
REQ-022 SHALL never emit an in-flight result after reset.
REQ-023 SHALL ignore in_valid on reset edges and drive in_ready=1 from the first cycle after reset.

Configuration
REQ-024 SHALL, with macro FP32_TO_INT_SIGNED_EN defined, produce a two's-complement signed result.
REQ-025 SHALL, under FP32_TO_INT_SIGNED_EN, saturate in-range class to e<=30:
- e>=31 or NaN or +Inf, positive: 0x7FFFFFFF, invalid 1.
- Negative e>=31 or -Inf: 0x80000000, invalid 1.
- Exception: exactly 0xCF000000 (-2^31) gives 0x80000000, invalid 0.
REQ-026 SHALL, under FP32_TO_INT_SIGNED_EN, negate negative in-range magnitudes on the edge that loads out_int.
REQ-027 SHALL keep the latency of REQ-017 unchanged under FP32_TO_INT_SIGNED_EN.
REQ-028 SHALL, without FP32_TO_INT_SIGNED_EN, follow REQ-012 exactly.

Verification
REQ-029 SHALL verify: in_fp32=0x3F800000 (1.0) -> N=23, out_valid 24 cycles after accept, out_int=0x00000001, invalid 0.
REQ-030 SHALL verify: 0x4B000000 (2^23) -> out_valid 1 cycle after accept, out_int=0x00800000; 0x4F000000 (2^31) unsigned -> 9 cycles, 0x80000000, invalid 0.
REQ-031 SHALL verify: 0x7FC00000 (NaN) and 0x4F800000 (2^32) -> 1 cycle, 0xFFFFFFFF, invalid 1 (signed build: 0x7FFFFFFF, invalid 1).
REQ-032 SHALL verify: 0xC0490FDB (-3.14159) -> unsigned 0x00000000 invalid 1; signed 0xFFFFFFFD invalid 0. 0xBF000000 (-0.5) -> 0, invalid 0, both builds.
REQ-033 SHALL verify backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 and a new operand -> out_int/out_valid stable, in_ready=0, new operand not accepted; out_ready=1 -> IDLE next cycle.
REQ-034 SHALL verify reset mid-operation: accept 0x3F800000, rst_n=0 for one edge at shift 10 -> next cycle out_valid=0, in_ready=1, out_int=0; no result for that operand ever appears.

Source files
------------

// File: rtl/fp32_to_int_if.sv
// Request/response bundle for the fp32_to_int converter.
// The master drives the operand and accepts the result; the slave (the
// converter) answers with the integer result and its invalid flag.
interface fp32_to_int_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_fp32;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_int;
  logic        out_invalid;

  modport master (
    output in_valid,
    output in_fp32,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_int,
    input  out_invalid
  );

  modport slave (
    input  in_valid,
    input  in_fp32,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_int,
    output out_invalid
  );
endinterface

// File: rtl/fp32_to_int.sv
// IEEE-754 single precision to 32-bit integer converter, truncating toward
// zero. The significand is moved into place one bit per clock, so latency is
// the distance between the exponent and 23, plus one cycle.
//
// Build option: FP32_TO_INT_SIGNED_EN selects a two's-complement signed result
// with saturation to 0x7FFFFFFF / 0x80000000. Without it the result is an
// unsigned integer and every negative operand with magnitude >= 1 is invalid.
module fp32_to_int (
  input  logic             clk,
  input  logic             rst_n,
  fp32_to_int_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] work_q, work_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        left_q, left_d;
  logic        neg_q, neg_d;
  logic [31:0] out_int_q, out_int_d;
  logic        out_invalid_q, out_invalid_d;
  logic        out_valid_q, out_valid_d;
  logic        in_ready_q, in_ready_d;

  // Operand fields
  logic        sign_s;
  logic [7:0]  exp_s;
  logic [22:0] man_s;

  // Classification results for the operand currently on the bus
  logic        special_s;
  logic [31:0] spec_int_s;
  logic        spec_inv_s;
  logic [7:0]  shift_n_s;
  logic        shift_left_s;
  logic [31:0] shifted_s;

  assign sign_s = bus.in_fp32[31];
  assign exp_s  = bus.in_fp32[30:23];
  assign man_s  = bus.in_fp32[22:0];

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_int     = out_int_q;
  assign bus.out_invalid = out_invalid_q;

  // Negate a magnitude into two's complement form
  function automatic logic [31:0] negate32(input logic [31:0] val);
    negate32 = (~val) + 32'd1;
  endfunction

  // Classify the operand: special results bypass the shifter entirely
  always_comb begin
    special_s  = 1'b0;
    spec_int_s = 32'd0;
    spec_inv_s = 1'b0;
    if (exp_s < 8'd127) begin
      // zero, denormal or |x| < 1: truncates to zero for either sign
      special_s = 1'b1;
    end else if (exp_s == 8'd255) begin
      special_s  = 1'b1;
      spec_inv_s = 1'b1;
`ifdef FP32_TO_INT_SIGNED_EN
      spec_int_s = ((man_s != 23'd0) || !sign_s) ? 32'h7FFF_FFFF : 32'h8000_0000;
`else
      spec_int_s = ((man_s != 23'd0) || !sign_s) ? 32'hFFFF_FFFF : 32'h0000_0000;
`endif
`ifdef FP32_TO_INT_SIGNED_EN
    end else if ((exp_s >= 8'd158) && (bus.in_fp32 != 32'hCF00_0000)) begin
      // |x| >= 2^31 saturates; exactly -2^31 is representable and passes
      special_s  = 1'b1;
      spec_inv_s = 1'b1;
      spec_int_s = sign_s ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      special_s = 1'b0;
    end
`else
    end else if (sign_s) begin
      // negative with magnitude >= 1 cannot be represented unsigned
      special_s  = 1'b1;
      spec_inv_s = 1'b1;
      spec_int_s = 32'h0000_0000;
    end else if (exp_s >= 8'd159) begin
      special_s  = 1'b1;
      spec_inv_s = 1'b1;
      spec_int_s = 32'hFFFF_FFFF;
    end else begin
      special_s = 1'b0;
    end
`endif
  end

  // Shift distance and direction relative to the binary point at bit 23
  always_comb begin
    shift_n_s    = 8'd0;
    shift_left_s = 1'b0;
    if (exp_s < 8'd150) begin
      shift_n_s    = 8'd150 - exp_s;
      shift_left_s = 1'b0;
    end else begin
      shift_n_s    = exp_s - 8'd150;
      shift_left_s = 1'b1;
    end
  end

  // One-bit step of the work register in the stored direction
  always_comb begin
    if (left_q) begin
      shifted_s = {work_q[30:0], 1'b0};
    end else begin
      shifted_s = {1'b0, work_q[31:1]};
    end
  end

  // Next-state and datapath logic for the IDLE/SHIFT/DONE controller
  always_comb begin
    state_d       = state_q;
    work_d        = work_q;
    cnt_d         = cnt_q;
    left_d        = left_q;
    neg_d         = neg_q;
    out_int_d     = out_int_q;
    out_invalid_d = out_invalid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (special_s) begin
            out_int_d     = spec_int_s;
            out_invalid_d = spec_inv_s;
            state_d       = DONE;
          end else begin
            work_d = {8'd0, 1'b1, man_s};
            cnt_d  = shift_n_s;
            left_d = shift_left_s;
`ifdef FP32_TO_INT_SIGNED_EN
            neg_d  = sign_s;
`else
            neg_d  = 1'b0;
`endif
            out_invalid_d = 1'b0;
            if (shift_n_s == 8'd0) begin
              out_int_d = neg_d ? negate32(work_d) : work_d;
              state_d   = DONE;
            end else begin
              state_d = SHIFT;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        work_d = shifted_s;
        cnt_d  = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          out_int_d = neg_q ? negate32(shifted_s) : shifted_s;
          state_d   = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      work_q        <= 32'd0;
      cnt_q         <= 8'd0;
      left_q        <= 1'b0;
      neg_q         <= 1'b0;
      out_int_q     <= 32'd0;
      out_invalid_q <= 1'b0;
      out_valid_q   <= 1'b0;
      in_ready_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      work_q        <= work_d;
      cnt_q         <= cnt_d;
      left_q        <= left_d;
      neg_q         <= neg_d;
      out_int_q     <= out_int_d;
      out_invalid_q <= out_invalid_d;
      out_valid_q   <= out_valid_d;
      in_ready_q    <= in_ready_d;
    end
  end

endmodule
